input_conditioner: RTL and testbench

Front-end conditioner between the board's raw push buttons and slide switches and the clock/alarm/stopwatch/mini-game control logic. It samples the 5 push-button and 15 SPDT inputs, synchronizes and debounces each one independently, and produces two kinds of output: clean levels, and single-cycle press/change pulses. The control logic consumes only these outputs and never sees raw pins. Up/down buttons optionally auto-repeat while held, which speeds up time and alarm setting.

---
 rtl/input_conditioner.sv | 137 +++++++++++++
 tb/tb_input_conditioner.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Synchronizes and debounces 5 push buttons and 15 slide switches into clean levels and 1-cycle pulses; INPUT_AUTOREPEAT_EN adds hold-to-repeat on push[1:0].
// Latency: 2+DEBOUNCE_CYCLES cycles from a clean raw edge to level/pulse; all outputs registered.
// Backpressure: none, inputs are free-running pins and outputs are always valid.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  push_raw,
    input  logic [14:0] spdt_raw,
    output logic [4:0]  push_level,
    output logic [4:0]  push_pulse,
    output logic [14:0] spdt_level,
    output logic        spdt_changed
);
    localparam int NB = 20;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("input_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [NB-1:0] w_raw;
    logic [NB-1:0] r_sync1;
    logic [NB-1:0] r_sync2;
    logic [NB-1:0] r_stable;
    logic [CW-1:0] r_cnt [NB];
    logic [4:0]    r_push_level;
    logic [4:0]    r_push_pulse;
    logic [4:0]    w_press;
    logic [14:0]   r_spdt_level;
    logic          r_spdt_changed;

`ifdef INPUT_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} rpt_state_t;
    rpt_state_t    r_rpt_state [2];
    logic [RW-1:0] r_rpt_cnt   [2];
`endif

    assign w_raw   = {spdt_raw, push_raw};
    // r_stable is what push_level will show next cycle, so a rising difference is a press.
    assign w_press = r_stable[4:0] & ~r_push_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < NB; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_push_level   <= '0;
            r_push_pulse   <= '0;
            r_spdt_level   <= '0;
            r_spdt_changed <= 1'b0;
`ifdef INPUT_AUTOREPEAT_EN
            for (int b = 0; b < 2; b++) begin
                r_rpt_state[b] <= S_IDLE;
                r_rpt_cnt[b]   <= '0;
            end
`endif
        end else begin
            r_push_level   <= r_stable[4:0];
            r_spdt_level   <= r_stable[NB-1:5];
            r_spdt_changed <= |(r_stable[NB-1:5] ^ r_spdt_level);
`ifdef INPUT_AUTOREPEAT_EN
            r_push_pulse[4:2] <= w_press[4:2];
            for (int b = 0; b < 2; b++) begin
                r_push_pulse[b] <= 1'b0;
                if (!r_stable[b]) begin
                    r_rpt_state[b] <= S_IDLE;
                    r_rpt_cnt[b]   <= '0;
                end else begin
                    case (r_rpt_state[b])
                        S_IDLE: begin
                            if (w_press[b]) begin
                                r_rpt_state[b]  <= S_DELAY;
                                r_rpt_cnt[b]    <= '0;
                                r_push_pulse[b] <= 1'b1;
                            end
                        end
                        S_DELAY: begin
                            if (r_rpt_cnt[b] == DLY_LAST) begin
                                r_rpt_state[b]  <= S_REPEAT;
                                r_rpt_cnt[b]    <= '0;
                                r_push_pulse[b] <= 1'b1;
                            end else begin
                                r_rpt_cnt[b] <= r_rpt_cnt[b] + RW'(1);
                            end
                        end
                        S_REPEAT: begin
                            if (r_rpt_cnt[b] == PER_LAST) begin
                                r_rpt_cnt[b]    <= '0;
                                r_push_pulse[b] <= 1'b1;
                            end else begin
                                r_rpt_cnt[b] <= r_rpt_cnt[b] + RW'(1);
                            end
                        end
                        default: r_rpt_state[b] <= S_IDLE;
                    endcase
                end
            end
`else
            r_push_pulse <= w_press;
`endif
        end
    end

    assign push_level   = r_push_level;
    assign push_pulse   = r_push_pulse;
    assign spdt_level   = r_spdt_level;
    assign spdt_changed = r_spdt_changed;
endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: scoreboard of expected output values keyed by cycle, popped by a monitor.
module tb_input_conditioner;
    localparam int DB  = 4;
    localparam int RD  = 8;
    localparam int RP  = 3;
    localparam int LAT = 2 + DB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  push_raw;
    logic [14:0] spdt_raw;
    logic [4:0]  push_level;
    logic [4:0]  push_pulse;
    logic [14:0] spdt_level;
    logic        spdt_changed;

    input_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_raw    (push_raw),
        .spdt_raw    (spdt_raw),
        .push_level  (push_level),
        .push_pulse  (push_pulse),
        .spdt_level  (spdt_level),
        .spdt_changed(spdt_changed)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;
    int pcnt [5] = '{0, 0, 0, 0, 0};

    // kind: 0 push_pulse, 1 push_level, 2 spdt_level, 3 spdt_changed
    typedef struct {
        int          cyc;
        int          kind;
        logic [14:0] val;
        string       tag;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_at(input int c, input int kind, input logic [14:0] val, input string tag);
        exp_t e;
        int   idx;
        e.cyc = c; e.kind = kind; e.val = val; e.tag = tag;
        idx = sb.size();
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc > c) idx = i;
        end
        sb.insert(idx, e);
    endtask

    function automatic logic [14:0] obs(input int kind);
        case (kind)
            0:       return {10'b0, push_pulse};
            1:       return {10'b0, push_level};
            2:       return spdt_level;
            default: return {14'b0, spdt_changed};
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: samples 2ns after each rising edge, away from the drive edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 5; i++) pcnt[i] += int'(push_pulse[i]);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.cyc != cyc) chk({e.tag, "_late"}, cyc, e.cyc);
                else              chk(e.tag, {17'b0, obs(e.kind)}, {17'b0, e.val});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int c;
        int e0;
        int p0;
        int n_exp;
        int t;

        rst_n    = 1'b1;
        push_raw = '1;
        spdt_raw = '1;
        #1 rst_n = 1'b0;

        // Reset with all inputs high
        tick(3);
        chk("rst_hold_plevel", push_level, 0);
        chk("rst_hold_ppulse", push_pulse, 0);
        chk("rst_hold_slevel", spdt_level, 0);
        chk("rst_hold_chg",    spdt_changed, 0);
        e0 = cyc + 1;
        rst_n = 1'b1;
        expect_at(e0 + LAT - 1, 1, 15'h0000, "rst_plevel_early");
        expect_at(e0 + LAT,     1, 15'h001F, "rst_plevel");
        expect_at(e0 + LAT,     2, 15'h7FFF, "rst_slevel");
        expect_at(e0 + LAT,     0, 15'h001F, "rst_pulse");
        expect_at(e0 + LAT,     3, 15'h0001, "rst_chg");
        expect_at(e0 + LAT + 1, 0, 15'h0000, "rst_pulse_end");
        expect_at(e0 + LAT + 1, 3, 15'h0000, "rst_chg_end");
        tick(12);

        // Drop everything: releases give no press pulse but one change pulse
        e0 = cyc + 1;
        push_raw = '0;
        spdt_raw = '0;
        expect_at(e0 + LAT, 1, 15'h0000, "clr_plevel");
        expect_at(e0 + LAT, 0, 15'h0000, "clr_nopulse");
        expect_at(e0 + LAT, 2, 15'h0000, "clr_slevel");
        expect_at(e0 + LAT, 3, 15'h0001, "clr_chg");
        tick(12);

        // Clean press on push[4], held 20 cycles
        p0 = pcnt[4];
        e0 = cyc + 1;
        push_raw[4] = 1'b1;
        expect_at(e0 + LAT - 1, 1, 15'h0000, "press_early");
        expect_at(e0 + LAT,     1, 15'h0010, "press_level");
        expect_at(e0 + LAT,     0, 15'h0010, "press_pulse");
        expect_at(e0 + LAT + 1, 0, 15'h0000, "press_pulse_end");
        tick(20);
        e0 = cyc + 1;
        push_raw[4] = 1'b0;
        expect_at(e0 + LAT - 1, 1, 15'h0010, "rel_early");
        expect_at(e0 + LAT,     1, 15'h0000, "rel_level");
        expect_at(e0 + LAT,     0, 15'h0000, "rel_nopulse");
        tick(12);
        chk("press_count", pcnt[4] - p0, 1);

        // Bounce on push[0]: 3-cycle phases never reach the threshold
        p0 = pcnt[0];
        e0 = cyc + 1;
        for (int k = 1; k <= 20; k++) expect_at(e0 + k, 1, 15'h0000, "bounce_level");
        for (int k = 0; k < 4; k++) begin
            push_raw[0] = (k % 2 == 0);
            tick(3);
        end
        push_raw[0] = 1'b0;
        tick(14);
        chk("bounce_count", pcnt[0] - p0, 0);

        // Hold push[1] for 30 cycles
        p0 = pcnt[1];
        e0 = cyc + 1;
        push_raw[1] = 1'b1;
        expect_at(e0 + LAT,     0, 15'h0002, "rpt_first");
        expect_at(e0 + LAT,     1, 15'h0002, "rpt_level");
        expect_at(e0 + LAT + 1, 0, 15'h0000, "rpt_first_end");
        n_exp = 1;
`ifdef INPUT_AUTOREPEAT_EN
        t = RD;
        while (t < 30) begin
            expect_at(e0 + LAT + t, 0, 15'h0002, "rpt_pulse");
            n_exp++;
            t += RP;
        end
`else
        t = RD;
        expect_at(e0 + LAT + t, 0, 15'h0000, "rpt_none");
`endif
        tick(30);
        push_raw[1] = 1'b0;
        expect_at(e0 + LAT + 30, 1, 15'h0000, "rpt_rel_level");
        expect_at(e0 + LAT + 30, 0, 15'h0000, "rpt_rel_nopulse");
        tick(12);
        chk("rpt_count", pcnt[1] - p0, n_exp);

        // Two switches flip on the same edge
        e0 = cyc + 1;
        spdt_raw[14] = 1'b1;
        spdt_raw[11] = 1'b1;
        expect_at(e0 + LAT - 1, 2, 15'h0000, "sw_early");
        expect_at(e0 + LAT - 1, 3, 15'h0000, "sw_chg_early");
        expect_at(e0 + LAT,     2, 15'h4800, "sw_level");
        expect_at(e0 + LAT,     3, 15'h0001, "sw_chg");
        expect_at(e0 + LAT + 1, 3, 15'h0000, "sw_chg_end");
        tick(12);

        // Reset while push[0] is held well past its press
        e0 = cyc + 1;
        push_raw[0] = 1'b1;
        expect_at(e0 + LAT, 0, 15'h0001, "mid_press");
        tick(LAT + RD + 4);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_plevel", push_level, 0);
        chk("mid_rst_ppulse", push_pulse, 0);
        chk("mid_rst_slevel", spdt_level, 0);
        chk("mid_rst_chg",    spdt_changed, 0);
        tick(2);
        p0 = pcnt[0];
        e0 = cyc + 1;
        rst_n = 1'b1;
        expect_at(e0 + LAT - 1, 1, 15'h0000, "mid_rel_early");
        expect_at(e0 + LAT,     0, 15'h0001, "mid_rel_pulse");
        expect_at(e0 + LAT,     1, 15'h0001, "mid_rel_level");
        expect_at(e0 + LAT,     2, 15'h4800, "mid_rel_slevel");
        expect_at(e0 + LAT,     3, 15'h0001, "mid_rel_chg");
        expect_at(e0 + LAT + 1, 0, 15'h0000, "mid_rel_pulse_end");
`ifdef INPUT_AUTOREPEAT_EN
        expect_at(e0 + LAT + RD, 0, 15'h0001, "mid_rel_repeat");
        n_exp = 2;
`else
        expect_at(e0 + LAT + RD, 0, 15'h0000, "mid_rel_norepeat");
        n_exp = 1;
`endif
        tick(LAT + RD + 2);
        chk("mid_rel_count", pcnt[0] - p0, n_exp);

        tick(4);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
